// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and frame line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flags and count are registered
// from the next-state pointers so they carry no input-to-output path.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic [CW-1:0]    wr_nxt;
  logic [CW-1:0]    rd_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign wr_nxt  = wr_ptr + CW'(push_ok);
  assign rd_nxt  = rd_ptr + CW'(pop_ok);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
      count  <= wr_nxt - rd_nxt;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Show-ahead read: head is valid whenever empty is low.
  assign rd_data_c = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained back-to-back by a
// serializer; line, active and done are registered one cycle after state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = 217,
  parameter  int unsigned FIFO_DEPTH   = 8,
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_Full,
  output logic                 o_Empty,
  output logic [CNT_W-1:0]     o_Count,
  output logic                 o_Overflow,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int unsigned      TMR_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned      IDX_W    = $clog2(DATA_BITS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state;
  uart_state_e          state_nxt;
  logic [TMR_W-1:0]     tmr;
  logic [TMR_W-1:0]     tmr_nxt;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [DATA_BITS-1:0] head_c;
  logic                 pop_c;
  logic                 tmr_last_c;
  logic                 serial_nxt;
  logic                 active_nxt;
  logic                 done_nxt;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .push      (i_TX_DV),
    .wr_data   (i_TX_Byte),
    .pop       (pop_c),
    .rd_data_c (head_c),
    .full      (o_Full),
    .empty     (o_Empty),
    .count     (o_Count)
  );

  assign tmr_last_c = (tmr == TMR_LAST);

  // Next-state, pop and next-output decode; outputs reflect the current state.
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr_last_c ? '0 : tmr + TMR_W'(1);
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop_c       = 1'b0;
    serial_nxt  = IDLE_LEVEL;
    active_nxt  = 1'b1;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        active_nxt = 1'b0;
        tmr_nxt    = '0;
        if (!o_Empty) begin
          pop_c     = 1'b1;
          shift_nxt = head_c;
          state_nxt = START;
        end
      end
      START: begin
        serial_nxt = START_LEVEL;
        if (tmr_last_c) begin
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        serial_nxt = shift[0];
        if (tmr_last_c) begin
          shift_nxt   = shift >> 1;
          bit_idx_nxt = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        serial_nxt = STOP_LEVEL;
        if (tmr_last_c) begin
          done_nxt = 1'b1;
          // A queued byte starts immediately so frames abut with no idle gap.
          if (!o_Empty) begin
            pop_c     = 1'b1;
            shift_nxt = head_c;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      tmr         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_TX_Serial <= IDLE_LEVEL;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
      o_Overflow  <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmr         <= tmr_nxt;
      bit_idx     <= bit_idx_nxt;
      shift       <= shift_nxt;
      o_TX_Serial <= serial_nxt;
      o_TX_Active <= active_nxt;
      o_TX_Done   <= done_nxt;
      o_Overflow  <= i_TX_DV && o_Full;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a 217-clock instance for real-baud framing and a
// 4-clock instance checked every cycle against a queue-based frame model.
module tb_uart_tx_fifo;

  localparam int unsigned CPB_A = 217;
  localparam int unsigned CPB_B = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int          FRAME_B = 10 * CPB_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, dv_a, full_a, empty_a, ovf_a, act_a, ser_a, done_a;
  logic [7:0]    byte_a;
  logic [CW-1:0] cnt_a;
  logic          rst_b, dv_b, full_b, empty_b, ovf_b, act_b, ser_b, done_b;
  logic [7:0]    byte_b;
  logic [CW-1:0] cnt_b;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH)) dut_a (
    .i_Clock(clk), .i_Reset(rst_a), .i_TX_DV(dv_a), .i_TX_Byte(byte_a),
    .o_Full(full_a), .o_Empty(empty_a), .o_Count(cnt_a), .o_Overflow(ovf_a),
    .o_TX_Active(act_a), .o_TX_Serial(ser_a), .o_TX_Done(done_a));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .i_Clock(clk), .i_Reset(rst_b), .i_TX_DV(dv_b), .i_TX_Byte(byte_b),
    .o_Full(full_b), .o_Empty(empty_b), .o_Count(cnt_b), .o_Overflow(ovf_b),
    .o_TX_Active(act_b), .o_TX_Serial(ser_b), .o_TX_Done(done_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference for dut_b: FIFO as a queue plus "clocks left in current frame".
  logic [7:0] mq[$];
  logic [7:0] popped_b[$];
  logic [7:0] cur_byte;
  int         frame_left;
  logic       e_ser, e_act, e_done, e_ovf;
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    int  slot;
    bit  full_m;
    if (rst_b) begin
      mq.delete();
      frame_left = 0;
      cur_byte   = 8'h00;
      e_ser = 1'b1; e_act = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      full_m = (mq.size() == DEPTH);
      if (frame_left == 0) begin
        e_ser = 1'b1; e_act = 1'b0; e_done = 1'b0;
      end else begin
        slot   = (FRAME_B - frame_left) / CPB_B;
        e_act  = 1'b1;
        e_done = (frame_left == 1);
        if (slot == 0)      e_ser = 1'b0;
        else if (slot == 9) e_ser = 1'b1;
        else                e_ser = cur_byte[slot-1];
      end
      e_ovf = dv_b && full_m;
      if (frame_left <= 1) begin
        if (mq.size() != 0) begin
          cur_byte = mq.pop_front();
          popped_b.push_back(cur_byte);
          frame_left = FRAME_B;
        end else begin
          frame_left = 0;
        end
      end else begin
        frame_left--;
      end
      if (dv_b && !full_m) mq.push_back(byte_b);
    end
  end

  bit   line_a[$];
  bit   line_b[$];
  int   act_cnt_a = 0, act_run_a = 0, act_max_a = 0, done_cnt_a = 0;
  int   done_cnt_b = 0, ovf_cnt_b = 0, maxcnt_b = 0;

  // One clock: sample both DUTs at negedge, compare dut_b to model, drive at posedge+1.
  task automatic cyc();
    @(negedge clk);
    line_a.push_back(ser_a);
    line_b.push_back(ser_b);
    if (act_a) begin
      act_cnt_a++; act_run_a++;
      if (act_run_a > act_max_a) act_max_a = act_run_a;
    end else begin
      act_run_a = 0;
    end
    done_cnt_a += int'(done_a);
    done_cnt_b += int'(done_b);
    ovf_cnt_b  += int'(ovf_b);
    if (int'(cnt_b) > maxcnt_b) maxcnt_b = int'(cnt_b);
    if (model_ok) begin
      check("b_serial",   ser_b,   e_ser);
      check("b_active",   act_b,   e_act);
      check("b_done",     done_b,  e_done);
      check("b_overflow", ovf_b,   e_ovf);
      check("b_count",    cnt_b,   mq.size());
      check("b_empty",    empty_b, mq.size() == 0);
      check("b_full",     full_b,  mq.size() == DEPTH);
    end
    @(posedge clk);
    #1;
  endtask

  // Line receiver: falling edge, then sample at bit centres.
  logic [7:0] dec_q[$];
  int         dec_start[$];
  int         frame_err;

  function automatic void decode(input bit ln[$], input int cpb);
    int i = 1;
    dec_q.delete();
    dec_start.delete();
    frame_err = 0;
    while (i < ln.size()) begin
      if (ln[i-1] && !ln[i] && (i + 10*cpb <= ln.size())) begin
        logic [7:0] b;
        if (ln[i + cpb/2]) frame_err++;
        for (int k = 0; k < 8; k++) b[k] = ln[i + cpb*(k+1) + cpb/2];
        if (!ln[i + 9*cpb + cpb/2]) frame_err++;
        dec_q.push_back(b);
        dec_start.push_back(i);
        i = i + 9*cpb + cpb/2;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic drain_b();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 3000) begin
      cyc();
      n++;
      if (empty_b && !act_b) quiet++; else quiet = 0;
    end
    check("b_drain_timeout", n < 3000, 1'b1);
  endtask

  task automatic push_b(input logic [7:0] b);
    byte_b = b; dv_b = 1'b1; cyc(); dv_b = 1'b0;
  endtask

  typedef struct {
    int         n;
    logic [7:0] base;
    int         gap;
    int         exp_ovf;
    int         exp_max;
  } burst_t;

  typedef struct {
    int delay;
    int exp_spacing;
  } gap_t;

  burst_t bt[6];
  gap_t   gt[3];

  initial begin
    logic [7:0] burst_a[5];
    int s0, n, d0, o0, p0, a0, exp_rx;

    bt[0] = '{10, 8'h00,  0, 1, 8};
    bt[1] = '{ 9, 8'h40,  0, 0, 8};
    bt[2] = '{ 6, 8'h80,  0, 0, 5};
    bt[3] = '{ 6, 8'h86,  0, 0, 5};
    bt[4] = '{ 6, 8'h8C,  0, 0, 5};
    bt[5] = '{ 4, 8'hE0, 45, 0, 1};
    gt[0] = '{40, 40};
    gt[1] = '{41, 41};
    gt[2] = '{43, 43};
    burst_a[0] = 8'h01; burst_a[1] = 8'h80; burst_a[2] = 8'hA5;
    burst_a[3] = 8'h5A; burst_a[4] = 8'hFF;

    rst_a = 1'b1; rst_b = 1'b1; dv_a = 1'b0; dv_b = 1'b0; byte_a = 8'h00; byte_b = 8'h00;
    @(posedge clk); #1;
    cyc(); cyc();
    check("a_rst_serial", ser_a, 1'b1);
    check("a_rst_active", act_a, 1'b0);
    check("a_rst_done",   done_a, 1'b0);
    check("a_rst_ovf",    ovf_a, 1'b0);
    check("a_rst_empty",  empty_a, 1'b1);
    check("a_rst_full",   full_a, 1'b0);
    check("a_rst_count",  cnt_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    cyc(); cyc();

    // Single byte at 217 clocks per bit.
    line_a.delete();
    a0 = act_cnt_a; d0 = done_cnt_a;
    byte_a = 8'h3F; dv_a = 1'b1; cyc(); dv_a = 1'b0;
    s0 = line_a.size();
    n = 0;
    do begin cyc(); n++; end while ((act_a || n < 5) && n < 25000);
    check("a1_timeout", n < 25000, 1'b1);
    decode(line_a, CPB_A);
    check("a1_rx_n", dec_q.size(), 1);
    if (dec_q.size() > 0) begin
      check("a1_rx_byte", dec_q[0], 8'h3F);
      check("a1_latency", dec_start[0] - s0, 2);
    end
    check("a1_frame_err", frame_err, 0);
    check("a1_active_clks", act_cnt_a - a0, 10 * CPB_A);
    check("a1_done", done_cnt_a - d0, 1);

    // Five-byte burst: continuous active window, five done pulses.
    line_a.delete();
    a0 = act_cnt_a; d0 = done_cnt_a; act_max_a = 0;
    for (int i = 0; i < 5; i++) begin
      byte_a = burst_a[i]; dv_a = 1'b1; cyc();
    end
    dv_a = 1'b0;
    n = 0;
    do begin cyc(); n++; end while ((act_a || n < 5) && n < 25000);
    check("a2_timeout", n < 25000, 1'b1);
    decode(line_a, CPB_A);
    check("a2_rx_n", dec_q.size(), 5);
    for (int i = 0; i < 5 && i < dec_q.size(); i++) check("a2_rx_byte", dec_q[i], burst_a[i]);
    check("a2_frame_err", frame_err, 0);
    check("a2_active_clks", act_cnt_a - a0, 5 * 10 * CPB_A);
    check("a2_active_run", act_max_a, 5 * 10 * CPB_A);
    check("a2_done", done_cnt_a - d0, 5);

    // Table of bursts on the 4-clock instance (overflow, exact fill, wrap, spaced).
    for (int t = 0; t < 6; t++) begin
      line_b.delete();
      d0 = done_cnt_b; o0 = ovf_cnt_b; maxcnt_b = 0;
      for (int i = 0; i < bt[t].n; i++) begin
        push_b(8'(bt[t].base + 8'(i)));
        repeat (bt[t].gap) cyc();
      end
      drain_b();
      decode(line_b, CPB_B);
      exp_rx = bt[t].n - bt[t].exp_ovf;
      check($sformatf("burst%0d_ovf", t), ovf_cnt_b - o0, bt[t].exp_ovf);
      check($sformatf("burst%0d_maxcnt", t), maxcnt_b, bt[t].exp_max);
      check($sformatf("burst%0d_rx_n", t), dec_q.size(), exp_rx);
      check($sformatf("burst%0d_done", t), done_cnt_b - d0, exp_rx);
      check($sformatf("burst%0d_frame_err", t), frame_err, 0);
      for (int i = 0; i < exp_rx && i < dec_q.size(); i++)
        check($sformatf("burst%0d_rx_byte%0d", t, i), dec_q[i], 8'(bt[t].base + 8'(i)));
      check($sformatf("burst%0d_end_count", t), cnt_b, 0);
      check($sformatf("burst%0d_end_empty", t), empty_b, 1'b1);
    end

    // Second write landing before, on, and after the final stop clock.
    for (int t = 0; t < 3; t++) begin
      line_b.delete();
      d0 = done_cnt_b;
      push_b(8'h5C);
      repeat (gt[t].delay - 1) cyc();
      push_b(8'hA3);
      drain_b();
      decode(line_b, CPB_B);
      check($sformatf("gap%0d_rx_n", t), dec_q.size(), 2);
      if (dec_q.size() == 2) begin
        check($sformatf("gap%0d_rx0", t), dec_q[0], 8'h5C);
        check($sformatf("gap%0d_rx1", t), dec_q[1], 8'hA3);
        check($sformatf("gap%0d_spacing", t), dec_start[1] - dec_start[0], gt[t].exp_spacing);
      end
      check($sformatf("gap%0d_done", t), done_cnt_b - d0, 2);
    end

    // Reset during data bit 3 with two bytes queued.
    push_b(8'hC3); push_b(8'hAA); push_b(8'hBB);
    repeat (16) cyc();
    check("rst_mid_queued", cnt_b, 2);
    check("rst_mid_in_frame", act_b, 1'b1);
    rst_b = 1'b1; cyc(); rst_b = 1'b0;
    check("rst_mid_serial", ser_b, 1'b1);
    check("rst_mid_active", act_b, 1'b0);
    check("rst_mid_count",  cnt_b, 0);
    check("rst_mid_empty",  empty_b, 1'b1);
    line_b.delete();
    d0 = done_cnt_b;
    repeat (60) cyc();
    check("rst_mid_no_done", done_cnt_b - d0, 0);
    push_b(8'h11);
    drain_b();
    decode(line_b, CPB_B);
    check("rst_mid_rx_n", dec_q.size(), 1);
    if (dec_q.size() > 0) check("rst_mid_rx", dec_q[0], 8'h11);

    // Random traffic; line content must match the model's pop order.
    line_b.delete();
    p0 = popped_b.size();
    for (int i = 0; i < 600; i++) begin
      byte_b = 8'($urandom);
      dv_b   = ($urandom_range(0, 99) < 6);
      cyc();
    end
    dv_b = 1'b0;
    drain_b();
    decode(line_b, CPB_B);
    check("rand_rx_n", dec_q.size(), popped_b.size() - p0);
    check("rand_frame_err", frame_err, 0);
    for (int i = 0; i < dec_q.size() && (p0 + i) < popped_b.size(); i++)
      check($sformatf("rand_rx_byte%0d", i), dec_q[i], popped_b[p0 + i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
